riscv_memory: RTL

Unified instruction/data memory that answers the `riscv_core` fetch and load/store ports. It is the responder end of the core's memory interface. After reset it holds the core in reset while a byte-stream loader fills the array with the program image. It then serves combinational reads and clocked byte-lane writes until the core reports `halted`.

---
 rtl/riscv_memory.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/riscv_memory.sv
// ----------------------------------------------------------------------------
// riscv_memory
//
// Unified instruction/data memory for riscv_core. After reset it holds the
// core in reset while a byte-stream loader fills the array with the program
// image. It then serves combinational reads on both ports and clocked
// four-lane stores. Once the core reports halted, all writes are blocked
// until the next reset.
//
// Ports
//   clk           rising-edge clock
//   rst_b         asynchronous active-low reset
//   inst_addr     fetch byte address        -> inst (little-endian word)
//   mem_addr      data byte address
//   mem_data_in   store lanes [0:3]         -> bytes (addr & ~3) + k
//   mem_data_out  load lanes  [0:3]         <- bytes (addr & ~3) + k
//   mem_write_en  store strobe, all four lanes
//   halted        core halt indication
//   load_valid / load_byte / load_last / load_ready
//                 byte-stream loader handshake
//   core_rst_b    registered active-low reset to the core
//   addr_err      sticky out-of-range access flag
// ----------------------------------------------------------------------------
module riscv_memory #(
   parameter int ADDR_BITS = 12
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic [31:0] inst_addr,
   output logic [31:0] inst,
   input  logic [31:0] mem_addr,
   input  logic [7:0]  mem_data_in  [0:3],
   output logic [7:0]  mem_data_out [0:3],
   input  logic        mem_write_en,
   input  logic        halted,
   input  logic        load_valid,
   input  logic [7:0]  load_byte,
   input  logic        load_last,
   output logic        load_ready,
   output logic        core_rst_b,
   output logic        addr_err
);

   localparam int DEPTH = 1 << ADDR_BITS;
   localparam logic [ADDR_BITS-1:0] LAST_PTR = {ADDR_BITS{1'b1}};

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   logic [7:0]           r_mem [0:DEPTH-1];
   state_t               r_state;
   logic [ADDR_BITS-1:0] r_load_ptr;
   logic                 r_load_ready;
   logic                 r_core_rst_b;
   logic                 r_addr_err;

   logic                 w_inst_ok;
   logic                 w_mem_ok;
   logic [ADDR_BITS-3:0] w_inst_word;
   logic [ADDR_BITS-3:0] w_mem_word;
   logic [7:0]           w_inst_lane [0:3];
   logic                 w_load_xfer;
   logic                 w_store;
   logic                 w_load_done;

   // In range means every address bit above the array width is zero.
   assign w_inst_ok   = (inst_addr >> ADDR_BITS) == 32'd0;
   assign w_mem_ok    = (mem_addr  >> ADDR_BITS) == 32'd0;
   // addr[1:0] is dropped: all accesses are forced to word alignment.
   assign w_inst_word = inst_addr[ADDR_BITS-1:2];
   assign w_mem_word  = mem_addr[ADDR_BITS-1:2];

   // Combinational reads; out-of-range reads return zero.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_inst_lane[gi]  = w_inst_ok ? r_mem[{w_inst_word, 2'(gi)}] : 8'h00;
      assign mem_data_out[gi] = w_mem_ok  ? r_mem[{w_mem_word,  2'(gi)}] : 8'h00;
   end

   assign inst = {w_inst_lane[3], w_inst_lane[2], w_inst_lane[1], w_inst_lane[0]};

   assign w_load_xfer = (r_state == ST_LOAD) && load_valid && r_load_ready;
   // A store in the same cycle the core raises halted is suppressed.
   assign w_store     = (r_state == ST_RUN) && mem_write_en && !halted && w_mem_ok;
   // The loader ends on load_last or when the final array byte is written.
   assign w_load_done = w_load_xfer && (load_last || (r_load_ptr == LAST_PTR));

   // Array storage has no reset: partially loaded contents survive rst_b.
   always_ff @(posedge clk) begin
      if (w_load_xfer) begin
         r_mem[r_load_ptr] <= load_byte;
      end else if (w_store) begin
         for (int k = 0; k < 4; k++) begin
            r_mem[{w_mem_word, 2'(k)}] <= mem_data_in[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state      <= ST_LOAD;
         r_load_ptr   <= '0;
         r_load_ready <= 1'b0;
         r_core_rst_b <= 1'b0;
         r_addr_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_LOAD: begin
               r_load_ready <= 1'b1;
               if (w_load_xfer) begin
                  // Saturate at the last byte so the pointer never wraps to 0.
                  if (r_load_ptr != LAST_PTR) begin
                     r_load_ptr <= r_load_ptr + 1'b1;
                  end
                  if (w_load_done) begin
                     r_state      <= ST_RUN;
                     r_load_ready <= 1'b0;
                     // Released on the same edge that writes the final byte,
                     // so the core's first fetch sees the complete image.
                     r_core_rst_b <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (!w_inst_ok || (mem_write_en && !w_mem_ok)) begin
                  r_addr_err <= 1'b1;
               end
               if (halted) begin
                  r_state <= ST_HALT;
               end
            end
            ST_HALT: begin
               // Terminal until reset.
            end
            default: begin
               r_state <= ST_HALT;
            end
         endcase
      end
   end

   assign load_ready = r_load_ready;
   assign core_rst_b = r_core_rst_b;
   assign addr_err   = r_addr_err;

endmodule
